// File: rtl/pmt_arb_pkg.sv
// Shared definitions for the PMT port arbiter: op codes, response tag,
// and the round-robin first-set-bit helper.
package pmt_arb_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_SRCH = 2'b11;

    // Ids are stored at the widest supported width so the tag type
    // does not depend on the requester count.
    localparam int unsigned MAX_REQ  = 256;
    localparam int unsigned TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic [TAG_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  mask,
        input logic [TAG_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic                found;
        logic [TAG_ID_W-1:0] idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = TAG_ID_W'((32'(ptr) + i) & (n - 32'd1));
            if (!found && (i < n) && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin first-set-bit finder: scans upward from ptr_i, wrapping.
module rr_priority_pick
    import pmt_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    assign any_o = |mask_i;
    assign idx_o = IW'(rr_pick(MAX_REQ'(mask_i), TAG_ID_W'(ptr_i), N));

endmodule

// File: rtl/pmt_port_arbiter.sv
// Shares one PMT crossbar port between NUM_REQ match tables and routes
// read/search responses back to the issuing requester.
module pmt_port_arbiter
    import pmt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_WIDTH      = 64,
    parameter int unsigned MAX_DEPTH_BITS = 8,
    parameter int unsigned RSP_LATENCY    = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*MAX_DEPTH_BITS-1:0] req_addr,
    input  logic [NUM_REQ*MAX_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*MAX_WIDTH-1:0]  req_mask,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pmt_wr_en,
    output logic                          pmt_rd_en,
    output logic                          pmt_search_en,
    output logic [MAX_DEPTH_BITS-1:0]     pmt_addr,
    output logic [MAX_WIDTH-1:0]          pmt_data,
    output logic [MAX_WIDTH-1:0]          pmt_mask,
    input  logic                          pmt_rsp_valid,
    input  logic [MAX_WIDTH-1:0]          pmt_rsp_data,
    input  logic                          pmt_rsp_match_found,
    input  logic [MAX_DEPTH_BITS-1:0]     pmt_rsp_match_addr,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [MAX_WIDTH-1:0]          rsp_data,
    output logic                          rsp_match_found,
    output logic [MAX_DEPTH_BITS-1:0]     rsp_match_addr,
    output logic                          err_unexpected_rsp
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]                op_a   [NUM_REQ];
    logic [MAX_DEPTH_BITS-1:0] addr_a [NUM_REQ];
    logic [MAX_WIDTH-1:0]      data_a [NUM_REQ];
    logic [MAX_WIDTH-1:0]      mask_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g]   = req_op[2*g +: 2];
        assign addr_a[g] = req_addr[g*MAX_DEPTH_BITS +: MAX_DEPTH_BITS];
        assign data_a[g] = req_data[g*MAX_WIDTH +: MAX_WIDTH];
        assign mask_a[g] = req_mask[g*MAX_WIDTH +: MAX_WIDTH];
    end

    logic [NUM_REQ-1:0] s_mask, m_mask;
    logic               s_any, m_any, use_s, grant;
    logic [IW-1:0]      s_idx, m_idx, win_id;
    logic [1:0]         win_op;

    always_comb begin
        s_mask = '0;
        m_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_mask[i] = req_valid[i] && (op_a[i] == OP_SRCH);
            m_mask[i] = req_valid[i] &&
                        ((op_a[i] == OP_WR) || (op_a[i] == OP_RD));
        end
    end

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] starve_q, starve_d;

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick_s (
        .mask_i (s_mask),
        .ptr_i  (rr_ptr_q),
        .any_o  (s_any),
        .idx_o  (s_idx)
    );

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick_m (
        .mask_i (m_mask),
        .ptr_i  (rr_ptr_q),
        .any_o  (m_any),
        .idx_o  (m_idx)
    );

    // Search wins unless reads/writes have already lost STARVE_LIMIT times.
    assign use_s  = s_any && ((starve_q < STARVE_MAX) || !m_any);
    assign grant  = rst_n && !arb_hold && (s_any || m_any);
    assign win_id = use_s ? s_idx : m_idx;
    assign win_op = op_a[win_id];

    assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        starve_d = starve_q;
        if (grant) begin
            rr_ptr_d = win_id + IW'(1);
        end
        if (!arb_hold) begin
            if (m_any && use_s) begin
                starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                    : starve_q + SW'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

    logic                      wr_en_q, rd_en_q, srch_en_q;
    logic [MAX_DEPTH_BITS-1:0] addr_q;
    logic [MAX_WIDTH-1:0]      data_q, mask_q;
    logic [IW-1:0]             iss_id_q;
    tag_t                      tag_q  [RSP_LATENCY];
    logic [RSP_LATENCY-1:0]    srch_q;
    tag_t                      new_tag, head;
    logic                      head_srch, retire;

    assign new_tag.valid = rd_en_q || srch_en_q;
    assign new_tag.id    = TAG_ID_W'(iss_id_q);
    assign head          = tag_q[RSP_LATENCY-1];
    assign head_srch     = srch_q[RSP_LATENCY-1];
    assign retire        = pmt_rsp_valid && head.valid;

    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [MAX_WIDTH-1:0]      rsp_data_q;
    logic                      rsp_found_q;
    logic [MAX_DEPTH_BITS-1:0] rsp_maddr_q;
    logic                      err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            starve_q    <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            srch_en_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            iss_id_q    <= '0;
            srch_q      <= '0;
            for (int k = 0; k < RSP_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_found_q <= 1'b0;
            rsp_maddr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            starve_q  <= starve_d;
            wr_en_q   <= grant && (win_op == OP_WR);
            rd_en_q   <= grant && (win_op == OP_RD);
            srch_en_q <= grant && (win_op == OP_SRCH);
            if (grant) begin
                addr_q   <= addr_a[win_id];
                data_q   <= data_a[win_id];
                mask_q   <= mask_a[win_id];
                iss_id_q <= win_id;
            end
            // Tags shift every cycle so each reaches the head on time.
            tag_q[0]  <= new_tag;
            srch_q[0] <= srch_en_q;
            for (int k = 1; k < RSP_LATENCY; k++) begin
                tag_q[k]  <= tag_q[k-1];
                srch_q[k] <= srch_q[k-1];
            end
            rsp_valid_q <= retire ? (NUM_REQ'(1) << head.id) : '0;
            if (retire) begin
                rsp_data_q  <= pmt_rsp_data;
                rsp_found_q <= head_srch && pmt_rsp_match_found;
                rsp_maddr_q <= head_srch ? pmt_rsp_match_addr : '0;
            end
            err_q <= err_q || (pmt_rsp_valid != head.valid);
        end
    end

    assign pmt_wr_en          = wr_en_q;
    assign pmt_rd_en          = rd_en_q;
    assign pmt_search_en      = srch_en_q;
    assign pmt_addr           = addr_q;
    assign pmt_data           = data_q;
    assign pmt_mask           = mask_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign rsp_match_found    = rsp_found_q;
    assign rsp_match_addr     = rsp_maddr_q;
    assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_pmt_port_arbiter.sv
// Directed bench for pmt_port_arbiter: cycle table for arbitration and
// routing, then hand sequences for read, write, error and reset cases.
module tb_pmt_port_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int DB = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              arb_hold = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [2*N-1:0]    req_op = '0;
    logic [N*DB-1:0]   req_addr = '0;
    logic [N*W-1:0]    req_data = '0;
    logic [N*W-1:0]    req_mask = '0;
    logic [N-1:0]      req_ready;
    logic              pmt_wr_en, pmt_rd_en, pmt_search_en;
    logic [DB-1:0]     pmt_addr;
    logic [W-1:0]      pmt_data, pmt_mask;
    logic              pmt_rsp_valid = 1'b0;
    logic [W-1:0]      pmt_rsp_data = '0;
    logic              pmt_rsp_match_found = 1'b0;
    logic [DB-1:0]     pmt_rsp_match_addr = '0;
    logic [N-1:0]      rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_match_found;
    logic [DB-1:0]     rsp_match_addr;
    logic              err_unexpected_rsp;

    always #5 clk = ~clk;

    pmt_port_arbiter #(
        .NUM_REQ(N), .MAX_WIDTH(W), .MAX_DEPTH_BITS(DB),
        .RSP_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arb_hold(arb_hold),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_data(req_data), .req_mask(req_mask), .req_ready(req_ready),
        .pmt_wr_en(pmt_wr_en), .pmt_rd_en(pmt_rd_en),
        .pmt_search_en(pmt_search_en), .pmt_addr(pmt_addr),
        .pmt_data(pmt_data), .pmt_mask(pmt_mask),
        .pmt_rsp_valid(pmt_rsp_valid), .pmt_rsp_data(pmt_rsp_data),
        .pmt_rsp_match_found(pmt_rsp_match_found),
        .pmt_rsp_match_addr(pmt_rsp_match_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_match_found(rsp_match_found),
        .rsp_match_addr(rsp_match_addr),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    typedef struct {
        logic       hold;
        logic [3:0] valid;
        logic [7:0] op;
        logic       rv_in;
        logic [7:0] ma_in;
        logic [3:0] x_ready;
        logic [2:0] x_en;
        logic [3:0] x_rv;
        logic [7:0] x_ma;
    } vec_t;

    vec_t tv [30];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int k, input logic h, input logic [3:0] v,
                        input logic [7:0] op, input logic rv,
                        input logic [7:0] ma, input logic [3:0] xr,
                        input logic [2:0] xe, input logic [3:0] xv,
                        input logic [7:0] xm);
        tv[k] = '{h, v, op, rv, ma, xr, xe, xv, xm};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] en3();
        return {pmt_wr_en, pmt_rd_en, pmt_search_en};
    endfunction

    initial begin
        // hold,valid,op,rsp_v,ma_in | ready,en{wr,rd,srch},rsp_valid,ma
        setv( 0, 1'b0, 4'hF, 8'hFF, 1'b0, 8'd0,  4'h1, 3'd0, 4'h0, 8'd0);
        setv( 1, 1'b0, 4'hF, 8'hFF, 1'b0, 8'd0,  4'h2, 3'd1, 4'h0, 8'd0);
        setv( 2, 1'b0, 4'hF, 8'hFF, 1'b0, 8'd0,  4'h4, 3'd1, 4'h0, 8'd0);
        setv( 3, 1'b0, 4'hF, 8'hFF, 1'b1, 8'd5,  4'h8, 3'd1, 4'h0, 8'd0);
        setv( 4, 1'b0, 4'hF, 8'hFF, 1'b1, 8'd10, 4'h1, 3'd1, 4'h1, 8'd5);
        setv( 5, 1'b0, 4'h0, 8'hFF, 1'b1, 8'd15, 4'h0, 3'd1, 4'h2, 8'd10);
        setv( 6, 1'b0, 4'h0, 8'hFF, 1'b1, 8'd20, 4'h0, 3'd0, 4'h4, 8'd15);
        setv( 7, 1'b0, 4'h0, 8'hFF, 1'b1, 8'd25, 4'h0, 3'd0, 4'h8, 8'd20);
        setv( 8, 1'b0, 4'h0, 8'hFF, 1'b0, 8'd0,  4'h0, 3'd0, 4'h1, 8'd25);
        setv( 9, 1'b0, 4'h0, 8'hFF, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd25);
        setv(10, 1'b0, 4'hF, 8'hFD, 1'b0, 8'd0,  4'h2, 3'd0, 4'h0, 8'd25);
        setv(11, 1'b0, 4'hF, 8'hFD, 1'b0, 8'd0,  4'h4, 3'd1, 4'h0, 8'd25);
        setv(12, 1'b0, 4'hF, 8'hFD, 1'b0, 8'd0,  4'h8, 3'd1, 4'h0, 8'd25);
        setv(13, 1'b0, 4'hF, 8'hFD, 1'b1, 8'd1,  4'h2, 3'd1, 4'h0, 8'd25);
        setv(14, 1'b0, 4'hF, 8'hFD, 1'b1, 8'd2,  4'h1, 3'd1, 4'h2, 8'd1);
        setv(15, 1'b0, 4'hE, 8'hFD, 1'b1, 8'd3,  4'h2, 3'd4, 4'h4, 8'd2);
        setv(16, 1'b0, 4'h0, 8'hFD, 1'b1, 8'd4,  4'h0, 3'd1, 4'h8, 8'd3);
        setv(17, 1'b0, 4'h0, 8'hFD, 1'b0, 8'd0,  4'h0, 3'd0, 4'h2, 8'd4);
        setv(18, 1'b0, 4'h0, 8'hFD, 1'b1, 8'd6,  4'h0, 3'd0, 4'h0, 8'd4);
        setv(19, 1'b0, 4'h0, 8'hFD, 1'b0, 8'd0,  4'h0, 3'd0, 4'h2, 8'd6);
        setv(20, 1'b1, 4'hF, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd6);
        setv(21, 1'b1, 4'hF, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd6);
        setv(22, 1'b1, 4'hF, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd6);
        setv(23, 1'b0, 4'hF, 8'hAA, 1'b0, 8'd0,  4'h4, 3'd0, 4'h0, 8'd6);
        setv(24, 1'b0, 4'h0, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd2, 4'h0, 8'd6);
        setv(25, 1'b0, 4'h0, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd6);
        setv(26, 1'b0, 4'h0, 8'hAA, 1'b1, 8'h77, 4'h0, 3'd0, 4'h0, 8'd6);
        setv(27, 1'b0, 4'h0, 8'hAA, 1'b0, 8'd0,  4'h0, 3'd0, 4'h4, 8'd0);
        setv(28, 1'b0, 4'h1, 8'hFC, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd0);
        setv(29, 1'b0, 4'h1, 8'hFC, 1'b0, 8'd0,  4'h0, 3'd0, 4'h0, 8'd0);

        req_addr = {8'h2A, 8'h07, 8'h11, 8'h10};
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = {32'hDA7A_0000, 32'(i)};
            req_mask[i*W +: W] = {32'hFFFF_0000, 32'(i)};
        end

        #1 rst_n = 1'b0;
        #1;
        chk("reset ready", 64'(req_ready), 64'(0));
        chk("reset en", 64'(en3()), 64'(0));
        chk("reset pmt_addr", 64'(pmt_addr), 64'(0));
        chk("reset pmt_data", pmt_data, 64'(0));
        chk("reset pmt_mask", pmt_mask, 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_data", rsp_data, 64'(0));
        chk("reset found", 64'(rsp_match_found), 64'(0));
        chk("reset maddr", 64'(rsp_match_addr), 64'(0));
        chk("reset err", 64'(err_unexpected_rsp), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        pmt_rsp_match_found = 1'b1;
        for (int k = 0; k < 30; k++) begin
            arb_hold           = tv[k].hold;
            req_valid          = tv[k].valid;
            req_op             = tv[k].op;
            pmt_rsp_valid      = tv[k].rv_in;
            pmt_rsp_match_addr = tv[k].ma_in;
            @(negedge clk);
            chk($sformatf("row%0d ready", k), 64'(req_ready),
                64'(tv[k].x_ready));
            chk($sformatf("row%0d en", k), 64'(en3()), 64'(tv[k].x_en));
            chk($sformatf("row%0d rsp_valid", k), 64'(rsp_valid),
                64'(tv[k].x_rv));
            chk($sformatf("row%0d maddr", k), 64'(rsp_match_addr),
                64'(tv[k].x_ma));
            chk($sformatf("row%0d err", k), 64'(err_unexpected_rsp),
                64'(0));
            cyc();
        end
        pmt_rsp_valid = 1'b0;

        // single read from requester 2
        req_valid = 4'b0100;
        req_op    = 8'h20;
        @(negedge clk);
        chk("rd ready", 64'(req_ready), 64'(4'b0100));
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("rd en", 64'(en3()), 64'(3'b010));
        chk("rd addr", 64'(pmt_addr), 64'(8'h07));
        cyc();
        @(negedge clk);
        chk("rd en drop", 64'(en3()), 64'(0));
        cyc();
        pmt_rsp_valid       = 1'b1;
        pmt_rsp_data        = 64'hACE0_0000_0700_0000;
        pmt_rsp_match_found = 1'b1;
        pmt_rsp_match_addr  = 8'h33;
        cyc();
        pmt_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rd rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("rd rsp_data", rsp_data, 64'hACE0_0000_0700_0000);
        chk("rd found", 64'(rsp_match_found), 64'(0));
        chk("rd maddr", 64'(rsp_match_addr), 64'(0));
        chk("rd err", 64'(err_unexpected_rsp), 64'(0));
        cyc();

        // write from requester 3
        req_valid = 4'b1000;
        req_op    = 8'h40;
        @(negedge clk);
        chk("wr ready", 64'(req_ready), 64'(4'b1000));
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("wr en", 64'(en3()), 64'(3'b100));
        chk("wr addr", 64'(pmt_addr), 64'(8'h2A));
        chk("wr data", pmt_data, 64'hDA7A_0000_0000_0003);
        chk("wr mask", pmt_mask, 64'hFFFF_0000_0000_0003);
        repeat (3) cyc();
        @(negedge clk);
        chk("wr no err", 64'(err_unexpected_rsp), 64'(0));
        chk("wr no rsp", 64'(rsp_valid), 64'(0));
        cyc();

        // unsolicited response
        pmt_rsp_valid = 1'b1;
        @(negedge clk);
        chk("unsol err before", 64'(err_unexpected_rsp), 64'(0));
        cyc();
        pmt_rsp_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("unsol err c%0d", c),
                64'(err_unexpected_rsp), 64'(1));
            chk($sformatf("unsol rsp c%0d", c), 64'(rsp_valid), 64'(0));
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("err cleared", 64'(err_unexpected_rsp), 64'(0));
        cyc();
        rst_n = 1'b1;

        // search issued, then reset one cycle later
        req_valid = 4'b0010;
        req_op    = 8'h0C;
        @(negedge clk);
        chk("mid ready", 64'(req_ready), 64'(4'b0010));
        cyc();
        chk("mid srch en", 64'(en3()), 64'(3'b001));
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", 64'(req_ready), 64'(0));
        chk("mid rst en", 64'(en3()), 64'(0));
        chk("mid rst addr", 64'(pmt_addr), 64'(0));
        chk("mid rst data", pmt_data, 64'(0));
        chk("mid rst rsp", 64'(rsp_valid), 64'(0));
        req_valid = '0;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("drop rsp c%0d", c), 64'(rsp_valid), 64'(0));
            chk($sformatf("drop err c%0d", c),
                64'(err_unexpected_rsp), 64'(0));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pmt_port_arbiter.md
Name: pmt_port_arbiter

Overview:
- Shares one PMT-pool crossbar port (write / read / search) between NUM_REQ logical match tables.
- Class-priority round-robin arbitration: search beats read/write, with a starvation cap.
- Registers the winning command onto the port and tracks in-flight read/search ops by fixed latency.
- Routes each read/search response back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of LMT requesters (power of 2, ≥2)
- MAX_WIDTH, 64, data/mask/key width
- MAX_DEPTH_BITS, 8, entry address width
- RSP_LATENCY, 2, cycles from command issue on the port to PMT response (≥1)
- STARVE_LIMIT, 4, maximum consecutive cycles a pending read/write may lose to search

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arb_hold  in  1  blocks all new grants (used during table reconfiguration)
- req_valid  in  NUM_REQ  per-requester request valid
- req_op  in  2*NUM_REQ  per-requester op: 01=write, 10=read, 11=search, 00=illegal
- req_addr  in  NUM_REQ*MAX_DEPTH_BITS  entry address (write/read)
- req_data  in  NUM_REQ*MAX_WIDTH  write data, or search key
- req_mask  in  NUM_REQ*MAX_WIDTH  write mask
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- pmt_wr_en / pmt_rd_en / pmt_search_en  out  1 each  port command strobes (mutually exclusive)
- pmt_addr  out  MAX_DEPTH_BITS  command address
- pmt_data  out  MAX_WIDTH  write data or search key
- pmt_mask  out  MAX_WIDTH  write mask
- pmt_rsp_valid  in  1  PMT response strobe
- pmt_rsp_data  in  MAX_WIDTH  read data
- pmt_rsp_match_found  in  1  search hit
- pmt_rsp_match_addr  in  MAX_DEPTH_BITS  search hit address
- rsp_valid  out  NUM_REQ  one-hot routed response strobe
- rsp_data / rsp_match_found / rsp_match_addr  out  MAX_WIDTH / 1 / MAX_DEPTH_BITS  response payload, shared across requesters
- err_unexpected_rsp  out  1  sticky error flag

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer = 0, starve counter = 0, tag pipeline empty.
  - Reset mid-operation drops all in-flight tags; no rsp_valid follows.
- Arbitration (combinational, each cycle):
  - No grant if arb_hold=1.
  - Requesters with op 00 are never granted; they stall until the op changes.
  - Classes: S = valid searches; M = valid reads/writes.
  - Winner class is S if S is non-empty and starve_cnt < STARVE_LIMIT; otherwise M if non-empty; otherwise S.
  - Within the winning class, the first valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ, is granted.
  - req_ready is asserted to that requester only.
- On each handshake:
  - rr_ptr = winner+1 (mod NUM_REQ).
  - The command is registered: the pmt_*_en strobe and its fields appear on the cycle following the handshake (1-cycle issue latency).
  - Back-to-back grants sustain 1 command/cycle.
- Starve counter:
  - Increments when M is non-empty and S wins (saturates at STARVE_LIMIT).
  - Clears when M wins or M is empty.
  - Not incremented while arb_hold=1.
- Tag pipeline:
  - A shift register of depth RSP_LATENCY, each stage holding {valid, requester id}.
  - Loaded when the port issues a read or search; writes load an invalid tag.
  - The tag reaches the head exactly RSP_LATENCY cycles after the port issue cycle.
- Response routing:
  - When pmt_rsp_valid=1 and the head tag is valid, the next cycle drives rsp_valid[id]=1 and registers the payload.
  - For reads: rsp_match_found=0 and rsp_match_addr=0.
- Error:
  - err_unexpected_rsp is set when pmt_rsp_valid=1 with an invalid head tag, or the head tag is valid with no pmt_rsp_valid (missing response).
  - A missing response produces no rsp_valid.
  - Cleared only by reset.
- Simultaneous events: a new issue and a response retirement in the same cycle are both handled (the pipeline shifts and loads).

Decomposition:
- Package pmt_arb_pkg holds:
  - op encodings OP_WR/OP_RD/OP_SRCH/OP_NONE
  - the tag struct {valid, id[$clog2(NUM_REQ)-1:0]}
  - the function rr_pick(mask, ptr)
- One sub-module is natural: rr_priority_pick (round-robin first-set-bit finder), instantiated twice, once per class.

Test Plan:
- Single read, requester 2, addr 0x07 → pmt_rd_en/pmt_addr=0x07 on cycle T+1; pmt_rsp_valid at T+3 with data 0xACE0_0000_0700_0000 → rsp_valid=4'b0100 at T+4 with the same data.
- All 4 requesters searching continuously from rr_ptr=0 → grants in order 0,1,2,3,0,…; each rsp_valid returns to the issuing id with its own match_addr (e.g. 5, 10).
- Requester 0 write pending while requesters 1–3 search continuously → write granted on cycle 5 (after 4 search wins); starve counter returns to 0.
- arb_hold=1 for 3 cycles while all requesters are valid → req_ready=0 and no pmt_*_en for those cycles; arbitration resumes from the saved rr_ptr.
- Unsolicited pmt_rsp_valid with an empty pipeline → err_unexpected_rsp=1 and stays high, rsp_valid stays 0; a later rst_n pulse clears it.
- Search issued, then rst_n asserted 1 cycle later → all outputs go to 0 immediately; after reset, no rsp_valid is produced for the dropped op.
